// File: rtl/uart_apb_tx_feeder.sv
// APB master feeding bytes from a valid/ready stream into the APB UART.
// After reset it programs BAUDDIV and CTRL. Then, for each byte, it polls STAT until TX is not full and writes DATA.
module uart_apb_tx_feeder #(
   parameter logic [19:0] BAUDDIV_INIT = 20'd16,
   parameter logic [6:0]  CTRL_INIT    = 7'h01,
   parameter logic [15:0] POLL_MAX     = 16'd1023
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        s_valid,
   input  logic [7:0]  s_data,
   output logic        s_ready,
   output logic        PSEL,
   output logic [9:0]  PADDR,
   output logic        PENABLE,
   output logic        PWRITE,
   output logic [31:0] PWDATA,
   input  logic [31:0] PRDATA,
   input  logic        PREADY,
   output logic        init_done,
   output logic        tx_drop
);

   // state       | meaning
   // BAUD_SETUP  | SETUP phase of the BAUDDIV write
   // BAUD_ACCESS | ACCESS phase of the BAUDDIV write, waiting on PREADY
   // CTRL_SETUP  | SETUP phase of the CTRL write
   // CTRL_ACCESS | ACCESS phase of the CTRL write, waiting on PREADY
   // IDLE        | bus idle, s_ready high, waiting for a byte
   // POLL_SETUP  | SETUP phase of a STAT read
   // POLL_ACCESS | ACCESS phase of a STAT read, branches on TX full
   // WR_SETUP    | SETUP phase of the DATA write
   // WR_ACCESS   | ACCESS phase of the DATA write, waiting on PREADY
   typedef enum logic [3:0] {
      BAUD_SETUP,
      BAUD_ACCESS,
      CTRL_SETUP,
      CTRL_ACCESS,
      IDLE,
      POLL_SETUP,
      POLL_ACCESS,
      WR_SETUP,
      WR_ACCESS
   } state_t;

   localparam logic [9:0]  ADDR_DATA = 10'd0;
   localparam logic [9:0]  ADDR_STAT = 10'd1;
   localparam logic [9:0]  ADDR_CTRL = 10'd2;
   localparam logic [9:0]  ADDR_BAUD = 10'd4;
   localparam logic [15:0] POLL_LAST = POLL_MAX - 16'd1;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [7:0]  r_byte;
   logic [15:0] r_poll_cnt;
   logic        r_init_done;
   logic        r_tx_drop;

   logic        w_psel;
   logic        w_penable;
   logic        w_pwrite;
   logic [9:0]  w_paddr;
   logic [31:0] w_pwdata;
   logic        w_accept;
   logic        w_poll_inc;
   logic        w_drop;
   logic        w_init_fin;
   logic        w_stat_full;
   logic        w_unused_prdata;

   assign w_stat_full     = PRDATA[0];
   assign w_unused_prdata = ^PRDATA[31:1];

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         r_state <= BAUD_SETUP;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // SETUP/ACCESS pairs decode the same address and data, so they stay stable
   // for the whole transfer however long PREADY is held low.
   always_comb begin
      w_state_nxt = r_state;
      w_psel      = 1'b0;
      w_penable   = 1'b0;
      w_pwrite    = 1'b0;
      w_paddr     = 10'd0;
      w_pwdata    = 32'd0;
      w_accept    = 1'b0;
      w_poll_inc  = 1'b0;
      w_drop      = 1'b0;
      w_init_fin  = 1'b0;
      case (r_state)
         BAUD_SETUP, BAUD_ACCESS: begin
            w_psel    = 1'b1;
            w_penable = (r_state == BAUD_ACCESS);
            w_pwrite  = 1'b1;
            w_paddr   = ADDR_BAUD;
            w_pwdata  = {12'd0, BAUDDIV_INIT};
            if (r_state == BAUD_SETUP) begin
               w_state_nxt = BAUD_ACCESS;
            end else if (PREADY) begin
               w_state_nxt = CTRL_SETUP;
            end
         end
         CTRL_SETUP, CTRL_ACCESS: begin
            w_psel    = 1'b1;
            w_penable = (r_state == CTRL_ACCESS);
            w_pwrite  = 1'b1;
            w_paddr   = ADDR_CTRL;
            w_pwdata  = {25'd0, CTRL_INIT};
            if (r_state == CTRL_SETUP) begin
               w_state_nxt = CTRL_ACCESS;
            end else if (PREADY) begin
               w_init_fin  = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         IDLE: begin
            if (s_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = POLL_SETUP;
            end
         end
         POLL_SETUP, POLL_ACCESS: begin
            w_psel    = 1'b1;
            w_penable = (r_state == POLL_ACCESS);
            w_paddr   = ADDR_STAT;
            if (r_state == POLL_SETUP) begin
               w_state_nxt = POLL_ACCESS;
            end else if (PREADY) begin
               if (!w_stat_full) begin
                  w_state_nxt = WR_SETUP;
               end else if (r_poll_cnt < POLL_LAST) begin
                  w_poll_inc  = 1'b1;
                  w_state_nxt = POLL_SETUP;
               end else begin
                  w_drop      = 1'b1;
                  w_state_nxt = IDLE;
               end
            end
         end
         WR_SETUP, WR_ACCESS: begin
            w_psel    = 1'b1;
            w_penable = (r_state == WR_ACCESS);
            w_pwrite  = 1'b1;
            w_paddr   = ADDR_DATA;
            w_pwdata  = {24'd0, r_byte};
            if (r_state == WR_SETUP) begin
               w_state_nxt = WR_ACCESS;
            end else if (PREADY) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = BAUD_SETUP;
         end
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         r_byte      <= 8'd0;
         r_poll_cnt  <= 16'd0;
         r_init_done <= 1'b0;
         r_tx_drop   <= 1'b0;
      end else begin
         r_tx_drop <= w_drop;
         if (w_init_fin) begin
            r_init_done <= 1'b1;
         end
         if (w_accept) begin
            r_byte     <= s_data;
            r_poll_cnt <= 16'd0;
         end else if (w_poll_inc) begin
            r_poll_cnt <= r_poll_cnt + 16'd1;
         end
      end
   end

   // The state resets to BAUD_SETUP, which decodes as an active SETUP.
   // Gating with PRESET keeps the bus quiet while reset is held.
   assign PSEL      = w_psel & ~PRESET;
   assign PENABLE   = w_penable & ~PRESET;
   assign PWRITE    = w_pwrite & ~PRESET;
   assign PADDR     = PRESET ? 10'd0 : w_paddr;
   assign PWDATA    = PRESET ? 32'd0 : w_pwdata;
   assign s_ready   = (r_state == IDLE);
   assign init_done = r_init_done;
   assign tx_drop   = r_tx_drop;

endmodule

// File: tb/tb_uart_apb_tx_feeder.sv
// Directed bench for uart_apb_tx_feeder: APB slave model, transfer log, and per-scenario checks.
// The DUT is built with POLL_MAX=4 so that the drop path is reachable in a handful of reads.
module tb_uart_apb_tx_feeder;

   logic        PCLK = 1'b0;
   logic        PRESET = 1'b1;
   logic        s_valid = 1'b0;
   logic [7:0]  s_data = 8'd0;
   logic        PREADY = 1'b1;
   logic        s_ready;
   logic        PSEL;
   logic [9:0]  PADDR;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        init_done;
   logic        tx_drop;

   int checks = 0;
   int errors = 0;

   int n_xfer = 0;
   int n_setup = 0;
   int n_stat = 0;
   int n_unstable = 0;
   logic [9:0]  log_addr  [0:255];
   logic        log_write [0:255];
   logic [31:0] log_wdata [0:255];
   logic [9:0]  cap_addr = 10'd0;
   logic        cap_write = 1'b0;
   logic [31:0] cap_wdata = 32'd0;

   logic stat_stuck = 1'b0;
   int   stat_limit = 0;

   assign PRDATA = {31'h2AAA_AAAA, (stat_stuck || (n_stat < stat_limit))};

   uart_apb_tx_feeder #(
      .BAUDDIV_INIT(20'd16),
      .CTRL_INIT(7'h01),
      .POLL_MAX(16'd4)
   ) dut (
      .PCLK(PCLK),
      .PRESET(PRESET),
      .s_valid(s_valid),
      .s_data(s_data),
      .s_ready(s_ready),
      .PSEL(PSEL),
      .PADDR(PADDR),
      .PENABLE(PENABLE),
      .PWRITE(PWRITE),
      .PWDATA(PWDATA),
      .PRDATA(PRDATA),
      .PREADY(PREADY),
      .init_done(init_done),
      .tx_drop(tx_drop)
   );

   always #5 PCLK = ~PCLK;

   // Log completed transfers and flag any address/data change inside a transfer.
   always @(posedge PCLK) begin
      if (PSEL && !PENABLE) begin
         n_setup   <= n_setup + 1;
         cap_addr  <= PADDR;
         cap_write <= PWRITE;
         cap_wdata <= PWDATA;
      end
      if (PSEL && PENABLE) begin
         if (PADDR !== cap_addr || PWRITE !== cap_write || PWDATA !== cap_wdata)
            n_unstable <= n_unstable + 1;
         if (PREADY) begin
            log_addr[n_xfer[7:0]]  <= PADDR;
            log_write[n_xfer[7:0]] <= PWRITE;
            log_wdata[n_xfer[7:0]] <= PWDATA;
            n_xfer <= n_xfer + 1;
            if (!PWRITE && PADDR == 10'd1) n_stat <= n_stat + 1;
         end
      end
   end

   task automatic test_reset();
      logic [44:0] exp_bus [0:3];
      logic [44:0] bus;
      int cyc;
      exp_bus[0] = {1'b1, 1'b0, 1'b1, 10'd4, 32'd16};
      exp_bus[1] = {1'b1, 1'b1, 1'b1, 10'd4, 32'd16};
      exp_bus[2] = {1'b1, 1'b0, 1'b1, 10'd2, 32'd1};
      exp_bus[3] = {1'b1, 1'b1, 1'b1, 10'd2, 32'd1};
      PRESET = 1'b1;
      PREADY = 1'b1;
      repeat (3) @(negedge PCLK);
      bus = {PSEL, PENABLE, PWRITE, PADDR, PWDATA};
      checks++;
      if (bus !== 45'd0 || s_ready !== 1'b0 || init_done !== 1'b0 || tx_drop !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: bus=%h s_ready=%b init_done=%b tx_drop=%b, want all 0",
                  bus, s_ready, init_done, tx_drop);
      end
      PRESET = 1'b0;
      #1;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) @(negedge PCLK);
         bus = {PSEL, PENABLE, PWRITE, PADDR, PWDATA};
         checks++;
         if (bus !== exp_bus[c] || s_ready !== 1'b0 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL init_cycle%0d: bus=%h s_ready=%b init_done=%b, want bus=%h s_ready=0 init_done=0",
                     c, bus, s_ready, init_done, exp_bus[c]);
         end
      end
      @(negedge PCLK);
      checks++;
      if (init_done !== 1'b1 || s_ready !== 1'b1 || PSEL !== 1'b0) begin
         errors++;
         $display("FAIL init_done_cycle4: init_done=%b s_ready=%b PSEL=%b, want 1 1 0",
                  init_done, s_ready, PSEL);
      end
   endtask

   task automatic test_single_byte();
      int base;
      int cyc;
      stat_stuck = 1'b0;
      stat_limit = n_stat;
      @(negedge PCLK);
      base = n_xfer;
      s_valid = 1'b1;
      s_data  = 8'h55;
      #1;
      checks++;
      if (s_ready !== 1'b1) begin
         errors++;
         $display("FAIL byte_ready_idle: s_ready=%b, want 1", s_ready);
      end
      @(negedge PCLK);
      s_valid = 1'b0;
      cyc = 1;
      checks++;
      if (s_ready !== 1'b0 || PSEL !== 1'b1 || PENABLE !== 1'b0 || PWRITE !== 1'b0 || PADDR !== 10'd1) begin
         errors++;
         $display("FAIL byte_stat_setup: s_ready=%b PSEL=%b PENABLE=%b PWRITE=%b PADDR=%0d, want 0 1 0 0 1",
                  s_ready, PSEL, PENABLE, PWRITE, PADDR);
      end
      while (s_ready !== 1'b1 && cyc < 60) begin
         @(negedge PCLK);
         cyc++;
      end
      checks++;
      if (cyc !== 5) begin
         errors++;
         $display("FAIL byte_latency: s_ready back after %0d cycles, want 5", cyc);
      end
      checks++;
      if (n_xfer - base !== 2 || log_addr[base[7:0]] !== 10'd1 || log_write[base[7:0]] !== 1'b0 ||
          log_addr[(base+1) & 255] !== 10'd0 || log_write[(base+1) & 255] !== 1'b1 ||
          log_wdata[(base+1) & 255] !== 32'h0000_0055) begin
         errors++;
         $display("FAIL byte_transfers: count=%0d second addr=%0d wdata=%h, want 2 transfers STAT read then addr 0 wdata 00000055",
                  n_xfer - base, log_addr[(base+1) & 255], log_wdata[(base+1) & 255]);
      end
   endtask

   task automatic test_poll_retry();
      int base;
      int sbase;
      int cyc;
      int bad;
      stat_stuck = 1'b0;
      stat_limit = n_stat + 3;
      @(negedge PCLK);
      base  = n_xfer;
      sbase = n_setup;
      s_valid = 1'b1;
      s_data  = 8'hA3;
      @(negedge PCLK);
      s_valid = 1'b0;
      cyc = 1;
      while (s_ready !== 1'b1 && cyc < 60) begin
         @(negedge PCLK);
         cyc++;
      end
      checks++;
      if (cyc !== 11) begin
         errors++;
         $display("FAIL poll_latency: s_ready back after %0d cycles, want 11", cyc);
      end
      bad = 0;
      for (int i = 0; i < 4; i++)
         if (log_addr[(base+i) & 255] !== 10'd1 || log_write[(base+i) & 255] !== 1'b0) bad++;
      checks++;
      if (n_xfer - base !== 5 || bad !== 0) begin
         errors++;
         $display("FAIL poll_reads: transfers=%0d bad_reads=%0d, want 5 transfers with 4 STAT reads", n_xfer - base, bad);
      end
      checks++;
      if (n_setup - sbase !== 5) begin
         errors++;
         $display("FAIL poll_setups: setup phases=%0d, want 5 (PENABLE drops between reads)", n_setup - sbase);
      end
      checks++;
      if (log_addr[(base+4) & 255] !== 10'd0 || log_wdata[(base+4) & 255] !== 32'h0000_00A3) begin
         errors++;
         $display("FAIL poll_write: addr=%0d wdata=%h, want 0 000000a3",
                  log_addr[(base+4) & 255], log_wdata[(base+4) & 255]);
      end
   endtask

   task automatic test_drop();
      int base;
      int cyc;
      int drops;
      int drop_cyc;
      stat_stuck = 1'b1;
      @(negedge PCLK);
      base = n_xfer;
      s_valid = 1'b1;
      s_data  = 8'h3C;
      @(negedge PCLK);
      s_valid = 1'b0;
      cyc = 1;
      drops = 0;
      drop_cyc = -1;
      while (s_ready !== 1'b1 && cyc < 60) begin
         @(negedge PCLK);
         cyc++;
         if (tx_drop === 1'b1) begin
            drops++;
            drop_cyc = cyc;
         end
      end
      @(negedge PCLK);
      if (tx_drop === 1'b1) drops++;
      checks++;
      if (cyc !== 9 || drops !== 1 || drop_cyc !== 9) begin
         errors++;
         $display("FAIL drop_pulse: idle at cycle %0d, pulses=%0d at cycle %0d, want idle 9, 1 pulse at 9",
                  cyc, drops, drop_cyc);
      end
      checks++;
      if (n_xfer - base !== 4 || log_addr[(base+3) & 255] !== 10'd1 || log_write[(base+3) & 255] !== 1'b0) begin
         errors++;
         $display("FAIL drop_reads: transfers=%0d, want exactly 4 STAT reads and no DATA write", n_xfer - base);
      end
      stat_stuck = 1'b0;
      stat_limit = n_stat;
      base = n_xfer;
      s_valid = 1'b1;
      s_data  = 8'h7E;
      @(negedge PCLK);
      s_valid = 1'b0;
      cyc = 1;
      while (s_ready !== 1'b1 && cyc < 60) begin
         @(negedge PCLK);
         cyc++;
      end
      checks++;
      if (cyc !== 5 || n_xfer - base !== 2 || log_wdata[(base+1) & 255] !== 32'h0000_007E || tx_drop !== 1'b0) begin
         errors++;
         $display("FAIL drop_next_byte: cycles=%0d transfers=%0d wdata=%h tx_drop=%b, want 5 2 0000007e 0",
                  cyc, n_xfer - base, log_wdata[(base+1) & 255], tx_drop);
      end
   endtask

   task automatic test_stall();
      int base;
      int ubase;
      int bad;
      stat_stuck = 1'b0;
      stat_limit = n_stat;
      @(negedge PCLK);
      base  = n_xfer;
      ubase = n_unstable;
      s_valid = 1'b1;
      s_data  = 8'h81;
      @(negedge PCLK);
      s_valid = 1'b0;
      repeat (2) @(negedge PCLK);
      PREADY = 1'b0;
      bad = 0;
      for (int c = 4; c <= 11; c++) begin
         @(negedge PCLK);
         if (c == 11) PREADY = 1'b1;
         if (PSEL !== 1'b1 || PENABLE !== 1'b1 || PWRITE !== 1'b1 || PADDR !== 10'd0 ||
             PWDATA !== 32'h0000_0081 || s_ready !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL stall_hold: %0d of 8 access cycles not holding addr 0 wdata 00000081, want 0", bad);
      end
      @(negedge PCLK);
      checks++;
      if (s_ready !== 1'b1 || PSEL !== 1'b0 || n_xfer - base !== 2 || n_unstable !== ubase) begin
         errors++;
         $display("FAIL stall_complete: s_ready=%b PSEL=%b transfers=%0d unstable=%0d, want 1 0 2 0",
                  s_ready, PSEL, n_xfer - base, n_unstable - ubase);
      end
   endtask

   task automatic test_back_to_back();
      int base;
      int cyc;
      stat_stuck = 1'b0;
      stat_limit = n_stat;
      @(negedge PCLK);
      base = n_xfer;
      s_valid = 1'b1;
      s_data  = 8'h11;
      @(negedge PCLK);
      s_data = 8'h22;
      cyc = 1;
      while (s_ready !== 1'b1 && cyc < 60) begin
         @(negedge PCLK);
         cyc++;
      end
      checks++;
      if (cyc !== 5) begin
         errors++;
         $display("FAIL b2b_first: second accept at cycle %0d, want 5", cyc);
      end
      @(negedge PCLK);
      s_valid = 1'b0;
      cyc++;
      while (s_ready !== 1'b1 && cyc < 60) begin
         @(negedge PCLK);
         cyc++;
      end
      checks++;
      if (cyc !== 10 || n_xfer - base !== 4 || log_wdata[(base+1) & 255] !== 32'h0000_0011 ||
          log_wdata[(base+3) & 255] !== 32'h0000_0022) begin
         errors++;
         $display("FAIL b2b_data: idle at %0d transfers=%0d wdata=%h,%h, want 10 4 00000011,00000022",
                  cyc, n_xfer - base, log_wdata[(base+1) & 255], log_wdata[(base+3) & 255]);
      end
   endtask

   task automatic test_reset_mid();
      int base;
      int cyc;
      stat_stuck = 1'b1;
      @(negedge PCLK);
      s_valid = 1'b1;
      s_data  = 8'h99;
      @(negedge PCLK);
      s_valid = 1'b0;
      @(negedge PCLK);
      checks++;
      if (PSEL !== 1'b1 || PENABLE !== 1'b1 || PADDR !== 10'd1) begin
         errors++;
         $display("FAIL rstmid_poll_access: PSEL=%b PENABLE=%b PADDR=%0d, want 1 1 1", PSEL, PENABLE, PADDR);
      end
      #1;
      PRESET = 1'b1;
      #1;
      checks++;
      if (PSEL !== 1'b0 || PENABLE !== 1'b0 || s_ready !== 1'b0 || init_done !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_async: PSEL=%b PENABLE=%b s_ready=%b init_done=%b, want 0 0 0 0",
                  PSEL, PENABLE, s_ready, init_done);
      end
      @(negedge PCLK);
      stat_stuck = 1'b0;
      base = n_xfer;
      PRESET = 1'b0;
      cyc = 0;
      #1;
      while (init_done !== 1'b1 && cyc < 40) begin
         @(negedge PCLK);
         cyc++;
      end
      checks++;
      if (cyc !== 4) begin
         errors++;
         $display("FAIL rstmid_reinit_time: init_done after %0d cycles, want 4", cyc);
      end
      repeat (10) @(negedge PCLK);
      checks++;
      if (n_xfer - base !== 2 || log_addr[base[7:0]] !== 10'd4 || log_wdata[base[7:0]] !== 32'd16 ||
          log_addr[(base+1) & 255] !== 10'd2 || log_wdata[(base+1) & 255] !== 32'd1 || s_ready !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_reinit: transfers=%0d first=%0d/%h second=%0d/%h s_ready=%b, want 2 4/10 2/1 and idle",
                  n_xfer - base, log_addr[base[7:0]], log_wdata[base[7:0]],
                  log_addr[(base+1) & 255], log_wdata[(base+1) & 255], s_ready);
      end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_poll_retry();
      test_drop();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
